// File: rtl/tc_accum_reader_pkg.sv
// Shared timer/counter constants and the reader state encoding.
package tc_accum_reader_pkg;

    localparam int unsigned TC_NUM_DEF   = 8;
    localparam int unsigned ACC_LEN_DEF  = 8;
    localparam int unsigned ADDR_LEN_DEF = 3;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } readerState_t;

endpackage

// File: rtl/tc_accum_reader_if.sv
// Processor-side request/response bundle of the accumulated-value reader.
interface tc_accum_reader_if
    import tc_accum_reader_pkg::*;
#(
    parameter int unsigned ACC_LEN  = ACC_LEN_DEF,
    parameter int unsigned ADDR_LEN = ADDR_LEN_DEF
);

    logic                rd_req;
    logic [ADDR_LEN-1:0] rd_addr;
    logic                src_sel;
    logic                snap_req;
    logic                scan_req;
    logic [ACC_LEN-1:0]  acc_out;
    logic [ADDR_LEN-1:0] acc_ch;
    logic                acc_valid;
    logic                addr_err;
    logic                busy;

    // Processor side: issues requests, consumes read data.
    modport master (
        output rd_req, rd_addr, src_sel, snap_req, scan_req,
        input  acc_out, acc_ch, acc_valid, addr_err, busy
    );

    // Reader side: accepts requests, returns read data.
    modport slave (
        input  rd_req, rd_addr, src_sel, snap_req, scan_req,
        output acc_out, acc_ch, acc_valid, addr_err, busy
    );

endinterface

// File: rtl/tc_acc_mux.sv
// Combinational TC_NUM-to-1 selector over a flattened accumulator bus.
module tc_acc_mux #(
    parameter int unsigned TC_NUM   = 8,
    parameter int unsigned ACC_LEN  = 8,
    parameter int unsigned ADDR_LEN = 3
) (
    input  logic [ACC_LEN*TC_NUM-1:0] accBus,
    input  logic [ADDR_LEN-1:0]       addr,
    output logic [ACC_LEN-1:0]        data_c,
    output logic                      outOfRange_c
);

    // Pick the addressed channel; unpopulated addresses read as zero.
    always_comb begin
        data_c = '0;
        for (int k = 0; k < TC_NUM; k++) begin
            if (addr == ADDR_LEN'(k)) begin
                data_c = accBus[k*ACC_LEN +: ACC_LEN];
            end
        end
    end

    // One extra bit so TC_NUM == 2**ADDR_LEN is representable.
    assign outOfRange_c = ({1'b0, addr} >= (ADDR_LEN+1)'(TC_NUM));

endmodule

// File: rtl/tc_accum_reader.sv
// Registered accumulated-value reader: single reads, snapshot, and scan stream.
module tc_accum_reader
    import tc_accum_reader_pkg::*;
#(
    parameter int unsigned TC_NUM   = TC_NUM_DEF,
    parameter int unsigned ACC_LEN  = ACC_LEN_DEF,
    parameter int unsigned ADDR_LEN = ADDR_LEN_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [ACC_LEN*TC_NUM-1:0] acc_in,
    tc_accum_reader_if.slave          bus
);

    localparam int unsigned IDX_LEN = ADDR_LEN + 1;

    readerState_t              state;
    logic [IDX_LEN-1:0]        scanIdx;
    logic [ACC_LEN*TC_NUM-1:0] snapBank;
    logic [ACC_LEN-1:0]        accOut;
    logic [ADDR_LEN-1:0]       accCh;
    logic                      accValid;
    logic                      addrErr;
    logic                      busyReg;

    logic [ADDR_LEN-1:0]       snapAddr_c;
    logic [ACC_LEN-1:0]        liveData_c;
    logic [ACC_LEN-1:0]        snapData_c;
    logic                      liveOor_c;
    logic                      snapOor_c;
    logic                      selOor_c;
    logic [ACC_LEN-1:0]        selData_c;

    // Snapshot port follows the scan index while streaming, else the read address.
    assign snapAddr_c = (state == SCAN) ? ADDR_LEN'(scanIdx) : bus.rd_addr;

    tc_acc_mux #(.TC_NUM(TC_NUM), .ACC_LEN(ACC_LEN), .ADDR_LEN(ADDR_LEN)) liveMux (
        .accBus       (acc_in),
        .addr         (bus.rd_addr),
        .data_c       (liveData_c),
        .outOfRange_c (liveOor_c)
    );

    tc_acc_mux #(.TC_NUM(TC_NUM), .ACC_LEN(ACC_LEN), .ADDR_LEN(ADDR_LEN)) snapMux (
        .accBus       (snapBank),
        .addr         (snapAddr_c),
        .data_c       (snapData_c),
        .outOfRange_c (snapOor_c)
    );

    // Both muxes see rd_addr in IDLE, so either range flag is valid for single reads.
    assign selOor_c  = bus.src_sel ? snapOor_c : liveOor_c;
    assign selData_c = selOor_c ? '0 : (bus.src_sel ? snapData_c : liveData_c);

    // Control FSM, snapshot bank and output registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            scanIdx  <= '0;
            snapBank <= '0;
            accOut   <= '0;
            accCh    <= '0;
            accValid <= 1'b0;
            addrErr  <= 1'b0;
            busyReg  <= 1'b0;
        end else begin
            accValid <= 1'b0;
            addrErr  <= 1'b0;
            case (state)
                IDLE: begin
                    // A scan always starts from a fresh capture.
                    if (bus.snap_req || bus.scan_req) begin
                        snapBank <= acc_in;
                    end
                    if (bus.scan_req) begin
                        state   <= SCAN;
                        scanIdx <= '0;
                        busyReg <= 1'b1;
                    end else if (bus.rd_req) begin
                        accOut   <= selData_c;
                        accCh    <= bus.rd_addr;
                        accValid <= 1'b1;
                        addrErr  <= selOor_c;
                    end
                end
                SCAN: begin
                    accOut   <= snapData_c;
                    accCh    <= ADDR_LEN'(scanIdx);
                    accValid <= 1'b1;
                    if (scanIdx == IDX_LEN'(TC_NUM - 1)) begin
                        state   <= IDLE;
                        scanIdx <= '0;
                        busyReg <= 1'b0;
                    end else begin
                        scanIdx <= scanIdx + IDX_LEN'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.acc_out   = accOut;
    assign bus.acc_ch    = accCh;
    assign bus.acc_valid = accValid;
    assign bus.addr_err  = addrErr;
    assign bus.busy      = busyReg;

endmodule

// File: tb/tb_tc_accum_reader.sv
// Bench: an 8-channel and a 6-channel reader share stimulus; a behavioural model checks both every cycle.
module tb_tc_accum_reader;

    logic       clk;
    logic       rstN;
    logic       rdReq, srcSel, snapReq, scanReq;
    logic [2:0] rdAddr;
    logic [7:0] live [8];
    logic [63:0] accIn8;
    logic [47:0] accIn6;

    int total = 0;
    int bad   = 0;

    tc_accum_reader_if #(.ACC_LEN(8), .ADDR_LEN(3)) bus8 ();
    tc_accum_reader_if #(.ACC_LEN(8), .ADDR_LEN(3)) bus6 ();

    assign bus8.rd_req = rdReq;   assign bus6.rd_req = rdReq;
    assign bus8.rd_addr = rdAddr; assign bus6.rd_addr = rdAddr;
    assign bus8.src_sel = srcSel; assign bus6.src_sel = srcSel;
    assign bus8.snap_req = snapReq; assign bus6.snap_req = snapReq;
    assign bus8.scan_req = scanReq; assign bus6.scan_req = scanReq;

    always_comb begin
        for (int k = 0; k < 8; k++) accIn8[k*8 +: 8] = live[k];
        for (int k = 0; k < 6; k++) accIn6[k*8 +: 8] = live[k];
    end

    tc_accum_reader #(.TC_NUM(8), .ACC_LEN(8), .ADDR_LEN(3)) dut8 (
        .clk(clk), .reset(rstN), .acc_in(accIn8), .bus(bus8.slave)
    );
    tc_accum_reader #(.TC_NUM(6), .ACC_LEN(8), .ADDR_LEN(3)) dut6 (
        .clk(clk), .reset(rstN), .acc_in(accIn6), .bus(bus6.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural model state, index 0 = 8-channel DUT, 1 = 6-channel DUT.
    logic [7:0] mSnap [2][8];
    int         mLeft [2];
    int         mPos  [2];
    logic [7:0] mOut  [2];
    logic [2:0] mCh   [2];
    logic       mValid[2];
    logic       mErr  [2];
    logic       mBusy [2];

    // Model: what each edge must produce, from the current request inputs.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            automatic int n = (d == 0) ? 8 : 6;
            automatic logic [7:0] oldSnap [8];
            if (!rstN) begin
                mOut[d] = 0; mCh[d] = 0; mValid[d] = 0; mErr[d] = 0; mBusy[d] = 0;
                mLeft[d] = 0; mPos[d] = 0;
                for (int k = 0; k < 8; k++) mSnap[d][k] = 0;
            end else begin
                mValid[d] = 0;
                mErr[d]   = 0;
                if (mLeft[d] > 0) begin
                    mOut[d]   = mSnap[d][mPos[d]];
                    mCh[d]    = 3'(mPos[d]);
                    mValid[d] = 1;
                    mPos[d]++;
                    mLeft[d]--;
                    mBusy[d]  = (mLeft[d] > 0);
                end else begin
                    for (int k = 0; k < 8; k++) oldSnap[k] = mSnap[d][k];
                    if (snapReq || scanReq)
                        for (int k = 0; k < n; k++) mSnap[d][k] = live[k];
                    if (scanReq) begin
                        mLeft[d] = n;
                        mPos[d]  = 0;
                        mBusy[d] = 1;
                    end else if (rdReq) begin
                        mValid[d] = 1;
                        mCh[d]    = rdAddr;
                        if (int'(rdAddr) >= n) begin
                            mOut[d] = 0;
                            mErr[d] = 1;
                        end else begin
                            mOut[d] = srcSel ? oldSnap[rdAddr] : live[rdAddr];
                        end
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare both DUTs against the model every cycle.
    always @(negedge clk) begin
        chk("dut8.acc_out",   32'(bus8.acc_out),   32'(mOut[0]));
        chk("dut8.acc_ch",    32'(bus8.acc_ch),    32'(mCh[0]));
        chk("dut8.acc_valid", 32'(bus8.acc_valid), 32'(mValid[0]));
        chk("dut8.addr_err",  32'(bus8.addr_err),  32'(mErr[0]));
        chk("dut8.busy",      32'(bus8.busy),      32'(mBusy[0]));
        chk("dut6.acc_out",   32'(bus6.acc_out),   32'(mOut[1]));
        chk("dut6.acc_ch",    32'(bus6.acc_ch),    32'(mCh[1]));
        chk("dut6.acc_valid", 32'(bus6.acc_valid), 32'(mValid[1]));
        chk("dut6.addr_err",  32'(bus6.addr_err),  32'(mErr[1]));
        chk("dut6.busy",      32'(bus6.busy),      32'(mBusy[1]));
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle();
        rdReq = 0; snapReq = 0; scanReq = 0;
    endtask

    task automatic rd(input logic [2:0] a, input logic s);
        rdReq = 1; rdAddr = a; srcSel = s;
        step();
        rdReq = 0;
    endtask

    initial begin
        rstN = 0; rdReq = 1; rdAddr = 3'd2; srcSel = 0; snapReq = 0; scanReq = 0;
        for (int k = 0; k < 8; k++) live[k] = 8'(8'h30 + k);

        // Reset held two clocks with a read pending.
        step(); step();
        chk("rst acc_out",   32'(bus8.acc_out), 0);
        chk("rst acc_valid", 32'(bus8.acc_valid), 0);
        chk("rst busy",      32'(bus8.busy), 0);
        rstN = 1; idle();
        rd(3'd3, 1'b1);
        chk("rst snap read", 32'(bus8.acc_out), 0);
        chk("rst snap valid", 32'(bus8.acc_valid), 1);

        // Live read with hold afterwards.
        for (int k = 0; k < 8; k++) live[k] = 8'(8'h10 + k);
        rd(3'd5, 1'b0);
        chk("live acc_out", 32'(bus8.acc_out), 32'h15);
        chk("live acc_ch",  32'(bus8.acc_ch), 5);
        chk("live valid",   32'(bus8.acc_valid), 1);
        step();
        chk("live pulse end", 32'(bus8.acc_valid), 0);
        chk("live hold",      32'(bus8.acc_out), 32'h15);

        // Snapshot coherence, including a same-edge capture and snapshot read.
        live[2] = 8'h42; snapReq = 1; step(); snapReq = 0;
        live[2] = 8'h99;
        rd(3'd2, 1'b1);
        chk("snap old", 32'(bus8.acc_out), 32'h42);
        rd(3'd2, 1'b0);
        chk("live new", 32'(bus8.acc_out), 32'h99);
        live[2] = 8'h55; snapReq = 1;
        rd(3'd2, 1'b1); snapReq = 0;
        chk("snap same-edge", 32'(bus8.acc_out), 32'h42);
        rd(3'd2, 1'b1);
        chk("snap after", 32'(bus8.acc_out), 32'h55);

        // Scan with inputs trashed after the capture and reads ignored.
        for (int k = 0; k < 8; k++) live[k] = 8'(8'h20 + k);
        scanReq = 1; step(); scanReq = 0;
        chk("scan E0 busy",  32'(bus8.busy), 1);
        chk("scan E0 valid", 32'(bus8.acc_valid), 0);
        for (int k = 0; k < 8; k++) live[k] = 8'hFF;
        rdReq = 1; rdAddr = 3'd1; srcSel = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("scan data",  32'(bus8.acc_out), 32'(8'h20 + i));
            chk("scan ch",    32'(bus8.acc_ch), 32'(i));
            chk("scan valid", 32'(bus8.acc_valid), 1);
            chk("scan busy",  32'(bus8.busy), (i < 7) ? 1 : 0);
        end
        rdReq = 0;
        step();

        // Out-of-range on the 6-channel reader, and the TC_NUM boundary.
        for (int k = 0; k < 8; k++) live[k] = 8'(8'h60 + k);
        rd(3'd7, 1'b0);
        chk("oor acc_out",   32'(bus6.acc_out), 0);
        chk("oor addr_err",  32'(bus6.addr_err), 1);
        chk("oor valid",     32'(bus6.acc_valid), 1);
        chk("inrange dut8",  32'(bus8.acc_out), 32'h67);
        rd(3'd6, 1'b1);
        chk("oor boundary",  32'(bus6.addr_err), 1);
        rd(3'd5, 1'b0);
        chk("last ch ok",    32'(bus6.addr_err), 0);
        chk("last ch data",  32'(bus6.acc_out), 32'h65);

        // Reset after the third strobe of a scan.
        scanReq = 1; step(); scanReq = 0;
        step(); step(); step();
        chk("mid third ch", 32'(bus8.acc_ch), 2);
        rstN = 0; step(); rstN = 1;
        chk("mid rst valid", 32'(bus8.acc_valid), 0);
        chk("mid rst busy",  32'(bus8.busy), 0);
        step(); step();
        chk("mid no strobe", 32'(bus8.acc_valid), 0);
        rd(3'd0, 1'b0);
        chk("post rd valid", 32'(bus8.acc_valid), 1);
        chk("post rd data",  32'(bus8.acc_out), 32'h60);

        // Randomised traffic, checked by the model.
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 2) == 0)
                for (int k = 0; k < 8; k++) live[k] = 8'($urandom);
            rstN    = ($urandom_range(0, 59) != 0);
            rdReq   = ($urandom_range(0, 1) == 1);
            rdAddr  = 3'($urandom_range(0, 7));
            srcSel  = ($urandom_range(0, 1) == 1);
            snapReq = ($urandom_range(0, 4) == 0);
            scanReq = ($urandom_range(0, 9) == 0);
            step();
        end
        idle(); rstN = 1;
        step(); step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
